// File: rtl/spi_pkg.sv
// Shared definitions for the SPI subnode: FSM state encoding, {CKP,CPH} mode
// constants and the default byte width.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_edge_sync.sv
// 1-bit input conditioner: optional 2-FF synchronizer (SPI_SUBNODE_SYNC_EN)
// followed by a registered edge detector giving level, rise and fall.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic lvl_p1;
    logic prev_p2;

`ifdef SPI_SUBNODE_SYNC_EN
    // stage p0: two-flop synchronizer, reset to the pin's idle level
    logic [1:0] sync_p0;

    always_ff @(posedge clk) begin
        if (!rst) sync_p0 <= {2{RST_VAL}};
        else      sync_p0 <= {sync_p0[0], din};
    end

    assign lvl_p1 = sync_p0[1];
`else
    assign lvl_p1 = din;
`endif

    // stage p2: previous level for edge detection
    always_ff @(posedge clk) begin
        if (!rst) prev_p2 <= RST_VAL;
        else      prev_p2 <= lvl_p1;
    end

    assign level = lvl_p1;
    assign rise  = lvl_p1 & ~prev_p2;
    assign fall  = ~lvl_p1 & prev_p2;

endmodule

// File: rtl/spi_subnode.sv
// SPI subnode endpoint, all four CKP/CPH modes, daisy-chainable shift register.
// Define SPI_SUBNODE_SYNC_EN to add 2-FF synchronizers on SCK, CS and MOSI.
module spi_subnode
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              CS,
    input  logic              MOSI,
    input  logic              CKP,
    input  logic              CPH,
    input  logic [DATA_W-1:0] data_sub_in,
    input  logic              load,
    output logic              MISO,
    output logic [DATA_W-1:0] data_rx,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sck_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .din(SCK),
        .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(CS),
        .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    // Leading edge leaves the CKP level; CPH picks which edge samples.
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = CKP ? sck_fall : sck_rise;
    assign trail_edge  = CKP ? sck_rise : sck_fall;
    assign sample_edge = CPH ? trail_edge : lead_edge;
    assign shift_edge  = CPH ? lead_edge  : trail_edge;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] tx_buf, shreg, tx_src, shreg_in;
    logic [CNT_W-1:0]  bit_cnt;
    logic              miso_bit;

    // Load coinciding with CS fall goes straight into the shift register.
    assign tx_src   = load ? data_sub_in : tx_buf;
    assign shreg_in = {shreg[DATA_W-2:0], mosi_s};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx_buf   <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            miso_bit <= 1'b0;
            data_rx  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) tx_buf <= data_sub_in;
                    if (cs_fall) begin
                        shreg    <= tx_src;
                        bit_cnt  <= '0;
                        miso_bit <= tx_src[DATA_W-1];
                    end else begin
                        miso_bit <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        bit_cnt  <= '0;
                        miso_bit <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            shreg <= shreg_in;
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                bit_cnt  <= '0;
                                data_rx  <= shreg_in;
                                rx_valid <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // MISO only moves on the shift edge; with CPH=1 the first
                        // shift edge of a byte re-presents the MSB already there.
                        if (shift_edge) miso_bit <= shreg[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign MISO = miso_bit;
    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_subnode.sv
// Directed bench for spi_subnode: acts as SPI main in all four modes and
// checks MISO bits, data_rx, rx_valid pulse counts, abort, load and reset.
module tb_spi_subnode;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCK, CS, MOSI, CKP, CPH, load;
    logic [7:0] data_sub_in;
    logic       MISO;
    logic [7:0] data_rx;
    logic       rx_valid, busy;

    int checks   = 0;
    int failures = 0;
    int rx_pulses = 0;

    spi_subnode #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .CKP(CKP), .CPH(CPH), .data_sub_in(data_sub_in), .load(load),
        .MISO(MISO), .data_rx(data_rx), .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid === 1'b1) rx_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic ckp, input logic cph);
        CKP = ckp;
        CPH = cph;
        SCK = ckp;
        tick(6);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        SCK = CKP;
        tick(6);
    endtask

    // Clocks nbits of tx (MSB first), capturing MISO where the main samples it
    // and confirming MISO holds through the subnode's sample edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits,
                             output logic [7:0] got, output logic stable_ok);
        got = 8'h00;
        stable_ok = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!CPH) begin
                MOSI = tx[i];
                tick(HALF);
                got[i] = MISO;
                SCK = ~CKP;
                tick(HALF);
                if (MISO !== got[i]) stable_ok = 1'b0;
                SCK = CKP;
            end else begin
                SCK = ~CKP;
                MOSI = tx[i];
                tick(HALF);
                got[i] = MISO;
                SCK = CKP;
                tick(HALF);
                if (MISO !== got[i]) stable_ok = 1'b0;
            end
        end
        if (!CPH) tick(HALF);
    endtask

    logic [7:0] got;
    logic       stable;
    int         p0;

    initial begin
        rst = 1'b0; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0; CKP = 1'b0; CPH = 1'b0;
        load = 1'b0; data_sub_in = 8'h00;
        tick(4);
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_data_rx", 32'(data_rx), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick(4);

        // Mode 0 basic transfer
        data_sub_in = 8'h3C; load = 1'b1; tick(1); load = 1'b0; data_sub_in = 8'h00;
        set_mode(1'b0, 1'b0);
        cs_low();
        chk("m0_busy", 32'(busy), 32'h1);
        p0 = rx_pulses;
        xfer_bits(8'hA5, 8, got, stable);
        chk("m0_miso", 32'(got), 32'h3C);
        chk("m0_stable", 32'(stable), 32'h1);
        chk("m0_data_rx", 32'(data_rx), 32'hA5);
        chk("m0_pulses", 32'(rx_pulses - p0), 32'd1);
        cs_high();
        chk("m0_idle_busy", 32'(busy), 32'h0);
        chk("m0_idle_miso", 32'(MISO), 32'h0);

        // Modes 1..3, tx_buf still 0x3C
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            data_sub_in = 8'h00;
            cs_low();
            p0 = rx_pulses;
            xfer_bits(8'hA5, 8, got, stable);
            chk($sformatf("m%0d_miso", m), 32'(got), 32'h3C);
            chk($sformatf("m%0d_stable", m), 32'(stable), 32'h1);
            chk($sformatf("m%0d_data_rx", m), 32'(data_rx), 32'hA5);
            chk($sformatf("m%0d_pulses", m), 32'(rx_pulses - p0), 32'd1);
            cs_high();
        end

        // Daisy chain: second byte echoes the first received byte
        set_mode(1'b0, 1'b0);
        cs_low();
        p0 = rx_pulses;
        xfer_bits(8'h81, 8, got, stable);
        chk("dc_first_miso", 32'(got), 32'h3C);
        xfer_bits(8'h00, 8, got, stable);
        chk("dc_second_miso", 32'(got), 32'h81);
        chk("dc_data_rx", 32'(data_rx), 32'h00);
        chk("dc_pulses", 32'(rx_pulses - p0), 32'd2);
        cs_high();

        // Abort after 5 bits, then a full transfer
        data_sub_in = 8'h00; load = 1'b1; tick(1); load = 1'b0;
        data_sub_in = 8'h3C; load = 1'b1; tick(1); load = 1'b0;
        set_mode(1'b1, 1'b1);
        cs_low();
        p0 = rx_pulses;
        xfer_bits(8'hFF, 5, got, stable);
        cs_high();
        chk("ab_pulses", 32'(rx_pulses - p0), 32'd0);
        chk("ab_data_rx", 32'(data_rx), 32'h00);
        chk("ab_busy", 32'(busy), 32'h0);
        cs_low();
        p0 = rx_pulses;
        xfer_bits(8'h5A, 8, got, stable);
        chk("ab_next_miso", 32'(got), 32'h3C);
        chk("ab_next_data_rx", 32'(data_rx), 32'h5A);
        chk("ab_next_pulses", 32'(rx_pulses - p0), 32'd1);
        cs_high();

        // load while busy is ignored
        set_mode(1'b0, 1'b0);
        cs_low();
        data_sub_in = 8'h77; load = 1'b1; tick(2); load = 1'b0;
        xfer_bits(8'h11, 8, got, stable);
        chk("ld_busy_miso", 32'(got), 32'h3C);
        cs_high();
        cs_low();
        xfer_bits(8'h22, 8, got, stable);
        chk("ld_next_miso", 32'(got), 32'h3C);
        chk("ld_data_rx", 32'(data_rx), 32'h22);
        cs_high();

        // Reset mid-byte
        cs_low();
        xfer_bits(8'hFF, 3, got, stable);
        rst = 1'b0;
        tick(1);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_miso", 32'(MISO), 32'h0);
        chk("mr_data_rx", 32'(data_rx), 32'h0);
        chk("mr_rx_valid", 32'(rx_valid), 32'h0);
        CS = 1'b1; SCK = CKP;
        tick(3);
        rst = 1'b1;
        tick(6);
        cs_low();
        p0 = rx_pulses;
        xfer_bits(8'hC3, 8, got, stable);
        chk("mr_next_miso", 32'(got), 32'h00);
        chk("mr_next_data_rx", 32'(data_rx), 32'hC3);
        chk("mr_next_pulses", 32'(rx_pulses - p0), 32'd1);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_subnode.md
# spi_subnode

SPI subnode (slave) endpoint. It receives bytes on MOSI and returns bytes on MISO under an external SPI main's SCK/CS, in any of the four CKP/CPH modes. It sits on the peripheral side of the team's SPI link. Its shift register passes each received byte back out on the following byte, so two or more subnodes can be daisy-chained on one CS.

## Interface
Parameters:
- DATA_W, 8, byte width; bit counter width is $clog2(DATA_W)+1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- SCK  in  1  serial clock from main, asynchronous to clk.
- CS  in  1  chip select, active-low, asynchronous.
- MOSI  in  1  serial data from main.
- CKP  in  1  SCK idle level; static while CS low.
- CPH  in  1  0: sample on leading edge; 1: sample on trailing edge.
- data_sub_in  in  DATA_W  byte to transmit in the next transaction.
- load  in  1  capture data_sub_in into tx_buf.
- MISO  out  DATA_W-bit shift MSB  serial data to main.
- data_rx  out  DATA_W  last complete received byte.
- rx_valid  out  1  one-clk pulse per completed byte.
- busy  out  1  high while the transaction is active.

## Operation
- Leading edge: SCK leaves the CKP level. Trailing edge: SCK returns to the CKP level.
- Sample edge: leading edge if CPH=0, trailing edge if CPH=1. Shift edge is the other edge.
- States: IDLE and ACTIVE (encoded in spi_pkg).
- IDLE:
  - MISO=0, busy=0.
  - When load=1, tx_buf <= data_sub_in.
  - On CS falling edge: shreg <= tx_buf, bit_cnt <= 0, go to ACTIVE.
- ACTIVE:
  - busy=1; MISO = shreg[DATA_W-1], MSB first.
  - load is ignored.
  - Sample edge: shreg <= {shreg[DATA_W-2:0], MOSI}, bit_cnt++.
  - CPH=1 only: the first shift edge of each byte shifts nothing. The MSB is already present from the CS fall or from the byte wrap.
  - CPH=0: MISO changes only on the shift edge. No extra shift is taken at the CS fall.
- Byte completion, on the sample edge that makes bit_cnt==DATA_W:
  - data_rx <= received byte; rx_valid=1 for one clk.
  - bit_cnt <= 0; stay in ACTIVE.
  - shreg keeps the received byte, so the next byte echoes it (daisy-chain).
- CS rising in ACTIVE at any bit: go to IDLE, bit_cnt <= 0.
  - A partial byte gives no rx_valid, and data_rx is unchanged.
- Simultaneous events:
  - CS rise with a sample edge in the same clk: CS wins, edge discarded.
  - load with CS fall in the same clk: the new data_sub_in goes straight to shreg.
- SCK edges while CS high are ignored.
- Reset mid-transfer returns to IDLE as below.
- Reset values: MISO=0, data_rx=0, rx_valid=0, busy=0, tx_buf=0, shreg=0, bit_cnt=0, state IDLE.

## Timing
- With the synchronizer compiled in (see Configuration):
  - SCK, CS and MOSI each pass 2 FFs before use.
  - An edge pulse is valid 2 clk after the pin edge is first sampled.
  - Actions resulting from it register at +3.
  - MOSI is delayed identically, so it stays aligned with SCK.
- MISO update: pin edge to MISO change is 3 clk.
- rx_valid rises 3 clk after the final sample pin edge.
- Minimum SCK half-period:
  - with synchronizer: 4 clk (SCK ≤ clk/8);
  - without synchronizer: 2 clk (SCK ≤ clk/4).
- Minimum CS-low to first SCK edge: 4 clk.

## Configuration
- Macro SPI_SUBNODE_SYNC_EN.
- Defined: 2-FF synchronizers on SCK, CS and MOSI; latency as in Timing; safe for asynchronous SCK.
- Undefined:
  - Inputs pass through a single edge-detect register only; all latencies drop by 2 clk.
  - Valid only when SCK is generated from clk, as by the team's SPI main.

## Structure
- Package spi_pkg:
  - state encoding (IDLE, ACTIVE);
  - mode constants MODE0..MODE3 as {CKP,CPH};
  - DATA_W default.
- Sub-module spi_edge_sync:
  - 1-bit synchronizer (depth set by the macro) plus registered edge detector;
  - outputs: level, rise, fall;
  - one instance each for SCK and CS, plus a level-only instance for MOSI.

## Test plan
- Mode 0 (CKP=0, CPH=0): load 0x3C, main sends 0xA5 → MISO shifts 0x3C, data_rx=0xA5, single rx_valid pulse.
- Modes 1, 2, 3: repeat 0x3C/0xA5 in each mode → identical data_rx/MISO results, bits changing on the correct edges.
- Daisy-chain: CS held low for 16 SCK cycles, main sends 0x81 then 0x00 → second byte out on MISO = 0x81, two rx_valid pulses.
- Abort: CS raised after 5 bits of 0xFF, then a full 0x5A transaction → no rx_valid for the partial byte; next data_rx=0x5A.
- load=1 with data_sub_in=0x77 while busy → ignored; the following transaction still sends the old tx_buf.
- rst=0 mid-byte → all outputs at reset values next clk; the next transaction sends tx_buf=0x00.
